regfile_wb_scheduler: RTL
=========================

// Module: regfile_wb_scheduler
// PURPOSE
//  Sequences the single write port of the 32x32 register file. Arbitrates writebacks from NREQ
//  producers (ALU, load unit, mul/div) round-robin, registers the winner onto wrt_sig/addr_wrt/in,
//  and keeps a per-register busy scoreboard that stalls issue on RAW/WAW hazards against
//  writes not yet committed. Sits between execute/memory stages and the register file.
// PARAMETERS
//  NREQ  3   number of writeback requesters (2..4)
//  AW    5   register address width
//  DW    32  register data width
// PORTS
//  clk           in   1        clock; all state updates on posedge
//  rst           in   1        reset; one clock, synchronous, active-high
//  req_valid     in   NREQ     requester i has a writeback pending
//  req_addr      in   NREQ*AW  destination of requester i, slice [i*AW +: AW]
//  req_data      in   NREQ*DW  data of requester i, slice [i*DW +: DW]
//  req_ready     out  NREQ     one-hot grant; transfer when req_valid[i] && req_ready[i]
//  wrt_sig       out  1        register file write enable (registered)
//  addr_wrt      out  AW       register file write address (registered)
//  in            out  DW       register file write data (registered)
//  issue_valid   in   1        decode presents an instruction this cycle
//  issue_dst_en  in   1        instruction writes a destination register
//  issue_dst     in   AW       destination register
//  issue_src0    in   AW       source operand 0
//  issue_src1    in   AW       source operand 1
//  stall         out  1        hold decode; issue not accepted this cycle
//  busy          out  2**AW    scoreboard snapshot (debug/verification)
// BEHAVIOUR
//  - Reset: wrt_sig=0, addr_wrt=0, in=0, busy=0, rr pointer=0. req_ready/stall combinational from
//    reset state, so req_ready=0 with no valids and stall=0.
//  - Arbitration: scan from pointer p upward mod NREQ; first valid i wins, req_ready=onehot(i).
//    On grant p <= (i+1) mod NREQ; no grant -> p unchanged. At most one grant per cycle.
//  - Latency: grant in cycle N -> wrt_sig=1, addr_wrt/in = winner's addr/data during N+1; register
//    file commits at end of N+1. No grant -> wrt_sig=0 in N+1, addr_wrt/in hold last values.
//  - Addr 0: grant still given (request consumed) but wrt_sig stays 0; busy[0] is always 0.
//  - Scoreboard: busy[d] set at posedge when issue accepted (issue_valid && !stall && issue_dst_en
//    && d!=0). busy[a] cleared at posedge ending a cycle with wrt_sig=1, addr_wrt=a.
//    Same register set and cleared on same edge -> set wins (newer producer outstanding).
//  - stall = issue_valid && (busy[src0] || busy[src1] || (issue_dst_en && busy[dst])).
//    No bypass: a register committing this cycle still stalls (file read is pre-write value).
//  - Requesters must only write registers marked busy; a write to a non-busy register commits
//    normally and leaves busy unchanged (clear of a 0 bit).
//  - rst mid-operation: registered pending write is dropped (wrt_sig=0 next cycle), all busy
//    cleared, pointer to 0; requesters must drop outstanding work on the same reset.
// STRUCTURE
//  - Shared package regfile_pkg: AW, DW, NREG=32, REG_ZERO=0, localparam widths reused by decode.
//  - Sub-module rr_arbiter (NREQ): req vector + pointer -> one-hot grant and next pointer.
//  - Top: arbiter, data/addr mux, output register, busy vector register, stall logic.
// TESTING
//  - Reset: assert rst 1 cycle with all req_valid=1 -> next cycle wrt_sig=0, busy=0, then grant=001.
//  - Round-robin: req_valid=111 held 6 cycles -> req_ready 001,010,100,001,010,100; wrt_sig=1 each
//    following cycle with matching addr_wrt.
//  - Latency: req1 addr=7 data=0xDEAD granted cycle N -> wrt_sig=1, addr_wrt=7, in=0xDEAD in N+1 only.
//  - Hazard: issue dst=5 accepted; next issue src0=5 -> stall=1 until cycle after wrt_sig commits
//    r5, stall=0 on the following cycle.
//  - Set/clear collision: wrt_sig for r9 and accepted issue dst=9 same cycle -> busy[9]=1 after edge.
//  - Addr 0: req addr=0 -> req_ready=1, wrt_sig=0 next cycle; issue dst=0 -> busy[0] stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file geometry used by the writeback scheduler and decode.
package regfile_pkg;

    localparam int unsigned REG_AW   = 5;
    localparam int unsigned REG_DW   = 32;
    localparam int unsigned NREG     = 32;
    localparam int unsigned REG_ZERO = 0;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [REG_DW-1:0] reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans upward from ptr (mod NREQ), grants the first requester
// and returns the pointer slot just past the winner.
module rr_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   next_ptr,
    output logic            any_grant
);

    logic [PW-1:0] idx;

    always_comb begin
        grant     = '0;
        next_ptr  = ptr;
        any_grant = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(ptr) + k) % NREQ);
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                next_ptr   = PW'((32'(idx) + 1) % NREQ);
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Register-file write-port sequencer: round-robin writeback arbitration, registered write
// port and a per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_wb_scheduler
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = REG_AW,
    parameter int unsigned DW   = REG_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              wrt_sig,
    output logic [AW-1:0]     addr_wrt,
    output logic [DW-1:0]     in,
    input  logic              issue_valid,
    input  logic              issue_dst_en,
    input  logic [AW-1:0]     issue_dst,
    input  logic [AW-1:0]     issue_src0,
    input  logic [AW-1:0]     issue_src1,
    output logic              stall,
    output logic [2**AW-1:0]  busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;
    logic [NREQ-1:0]   grant;
    logic              any_grant;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_data;
    logic [2**AW-1:0]  busy_q;
    logic [2**AW-1:0]  busy_d;
    logic              issue_accept;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .next_ptr  (ptr_d),
        .any_grant (any_grant)
    );

    assign req_ready = grant;

    // Grant is one-hot, so an OR-mux is enough.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | req_addr[i*AW +: AW];
                sel_data = sel_data | req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            wrt_sig  <= 1'b0;
            addr_wrt <= '0;
            in       <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (any_grant) begin
                // A write to the zero register is consumed but never reaches the file.
                wrt_sig  <= (sel_addr != AW'(REG_ZERO));
                addr_wrt <= sel_addr;
                in       <= sel_data;
            end else begin
                wrt_sig <= 1'b0;
            end
        end
    end

    assign stall = issue_valid &&
                   (busy_q[issue_src0] || busy_q[issue_src1] ||
                    (issue_dst_en && busy_q[issue_dst]));

    assign issue_accept = issue_valid && !stall && issue_dst_en;

    // Set after clear: a newer producer of the same register stays outstanding.
    always_comb begin
        busy_d = busy_q;
        if (wrt_sig) begin
            busy_d[addr_wrt] = 1'b0;
        end
        if (issue_accept) begin
            busy_d[issue_dst] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule
